// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic             a0, b0, dbit, br_nxt;

   assign a0     = a_sh_q[0];
   assign b0     = b_sh_q[0];
   assign dbit   = a0 ^ b0 ^ br_q;
   assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      done_d  = 1'b0;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               br_d    = bus.bin;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
               res_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d  = {dbit, res_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_nxt;
            cnt_d  = cnt_q + CW'(1);
            // The last bit processed is the result MSB, so it feeds ovf directly.
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d  = {dbit, res_q[WIDTH-1:1]};
               bout_d  = br_nxt;
               ovf_d   = (a_msb_q ^ b_msb_q) & (dbit ^ a_msb_q);
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive checks of serial_subtractor at WIDTH=4
module tb_serial_subtractor;
   localparam int W = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_op(input string tag, input logic [3:0] a_in, input logic [3:0] b_in,
                        input logic bin_in, input logic [3:0] exp_diff,
                        input logic exp_bout, input logic exp_ovf, input bit full);
      int lat;
      int busy_n;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a_in;
      bus.b     = b_in;
      bus.bin   = bin_in;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = ~a_in;
      bus.b     = ~b_in;
      bus.bin   = ~bin_in;
      lat    = 0;
      busy_n = bus.busy ? 1 : 0;
      while (!bus.done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy) busy_n++;
      end
      if (full) begin
         check({tag, "_latency"}, lat, W);
         check({tag, "_busy_cycles"}, busy_n, W);
      end else if (lat >= 20) begin
         check({tag, "_timeout"}, lat, W);
      end
      check({tag, "_diff"}, bus.diff, exp_diff);
      check({tag, "_bout"}, bus.bout, exp_bout);
      check({tag, "_ovf"}, bus.ovf, exp_ovf);
      if (full) begin
         @(posedge clk);
         #1;
         check({tag, "_done_one_cycle"}, bus.done, 1'b0);
      end
   endtask

   initial begin
      int done_n;
      int t0, t1, t2;
      int k;
      logic [3:0] hold_diff;
      logic [4:0] ref5;
      logic       ref_ovf;
      logic [3:0] av, bv;

      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", bus.busy, 1'b0);
      check("reset_done", bus.done, 1'b0);
      check("reset_diff", bus.diff, 4'h0);
      check("reset_bout", bus.bout, 1'b0);
      check("reset_ovf", bus.ovf, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      do_op("basic", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
      do_op("borrow", 4'b0010, 4'b0011, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b1);
      do_op("bin_eq", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
      do_op("ovf_neg", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b1);
      do_op("ovf_pos", 4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1);

      // Second start arrives while busy and must be ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'b1111; bus.b = 4'b0001; bus.bin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'b0000; bus.b = 4'b0001;
      @(negedge clk);
      bus.start = 1'b0;
      done_n    = 0;
      hold_diff = 4'h0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            done_n++;
            hold_diff = bus.diff;
         end
      end
      check("ignore_start_done_count", done_n, 1);
      check("ignore_start_diff", hold_diff, 4'b1110);

      // start held high: back-to-back operations every WIDTH+1 cycles.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'b0101; bus.b = 4'b0011; bus.bin = 1'b0;
      t0 = -1; t1 = -1; t2 = -1;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            if (t0 < 0) t0 = i;
            else if (t1 < 0) t1 = i;
            else if (t2 < 0) t2 = i;
         end
      end
      bus.start = 1'b0;
      check("held_first_done", t0, W + 1);
      check("held_period_1", t1 - t0, W + 1);
      check("held_period_2", t2 - t1, W + 1);
      check("held_diff", bus.diff, 4'b0010);
      k = 0;
      while (bus.busy && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("held_drain", bus.busy, 1'b0);

      // Abort mid-run with reset.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'b1001; bus.b = 4'b0010; bus.bin = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", bus.busy, 1'b0);
      check("abort_done", bus.done, 1'b0);
      check("abort_diff", bus.diff, 4'h0);
      check("abort_bout", bus.bout, 1'b0);
      check("abort_ovf", bus.ovf, 1'b0);
      @(negedge clk);
      rst    = 1'b0;
      done_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) done_n++;
      end
      check("abort_no_done", done_n, 0);
      do_op("after_abort", 4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 512; i++) begin
         av      = i[7:4];
         bv      = i[3:0];
         ref5    = {1'b0, av} - {1'b0, bv} - {4'b0, i[8]};
         ref_ovf = (av[3] ^ bv[3]) & (ref5[3] ^ av[3]);
         do_op($sformatf("exh_%0d", i), av, bv, i[8], ref5[3:0], ref5[4], ref_ovf, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor; the counterpart to the team's 4-bit ripple adder.
- Computes diff = a - b - bin, LSB first, one bit per clock, with a start/busy/done handshake.
- Used where area matters more than latency.
- Provides borrow-out and a signed-overflow flag, so arithmetic units can be built from the add and subtract blocks.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend (unsigned or two's complement)
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results updated on the same edge
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
- ovf  output  1  signed overflow: (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB])

Behaviour:
- Reset: while rst=1, all flops clear asynchronously.
  - busy=0, done=0, diff=0, bout=0, ovf=0.
  - FSM enters IDLE; internal shift registers, bit counter and borrow flop are cleared.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge k:
  - Latch a, b and bin into internal registers. The borrow flop is loaded with bin.
  - Counter is set to 0 and the FSM goes to RUN; busy=1 from edge k.
- RUN, each edge:
  - Take the operand LSBs a0, b0 and the borrow br.
  - Difference bit d = a0^b0^br.
  - Next borrow br' = (~a0 & b0) | (~(a0^b0) & br).
  - d is shifted into the MSB of the result shift register; both operand registers shift right by 1.
  - Counter increments.
- Completion:
  - On the edge where the counter reaches WIDTH-1, i.e. edge k+WIDTH, the assembled result including that edge's bit is loaded into diff.
  - The final br' is loaded into bout, and ovf is computed from the latched operand MSBs and the result MSB.
  - On that same edge: done=1 for exactly one cycle, busy=0, FSM goes to IDLE.
- Latency: exactly WIDTH cycles from the accept edge to the done edge. Throughput is one operation per WIDTH+1 cycles when start is held high.
- Holding rules:
  - diff, bout and ovf change only on a done edge; during RUN they keep the previous result.
  - a, b and bin may change freely after the accept edge.
- Boundary conditions:
  - start=1 while busy=1: ignored, with no effect on the operation in progress.
  - start=1 during the done cycle: accepted at the next edge, giving back-to-back operation.
  - rst asserted mid-RUN: the operation is aborted and all outputs clear immediately. No done pulse is generated; after release the block is in IDLE.
  - Wrap-around: the result is modulo 2^WIDTH, e.g. 0-1 gives all ones with bout=1.
  - bin=1 with a=b: result is all ones, bout=1.

Test Plan:
- Basic: a=0101, b=0011, bin=0, start pulse → done 4 cycles after accept; diff=0010, bout=0, ovf=0; busy high for 4 cycles.
- Borrow: a=0010, b=0011, bin=0 → diff=1111, bout=1, ovf=0. Then a=0000, b=0000, bin=1 → diff=1111, bout=1.
- Signed overflow: a=1000, b=0001, bin=0 → diff=0111, bout=0, ovf=1. Then a=0111, b=1111, bin=0 → diff=1000, bout=1, ovf=1.
- Handshake:
  - Pulse start with a=1111, b=0001; pulse start again 2 cycles later with a=0000, b=0001. Only diff=1110 is produced and only one done pulse is seen.
  - Holding start=1 continuously gives done pulses every 5 cycles.
- Reset mid-op: start with a=1001, b=0010, then assert rst after 2 cycles → busy=0, done=0, diff=0 immediately; no done pulse follows. Next operation, 0110-0001, gives 0101.
- Exhaustive: all 512 combinations of a, b and bin at WIDTH=4 are checked against the reference model {bout,diff} = {1'b0,a} - {1'b0,b} - bin, plus ovf.
